vga_pixel_renderer: RTL
=======================

Name: vga_pixel_renderer

Overview:
- Downstream consumer of the VGA timing generator: takes pixel coordinates, sync and video_on, and produces 8-bit RGB plus sync outputs, all delayed to the same cycle.
- Renders a 40x30 background of 16x16 tiles from external synchronous tile-map and tile-pattern ROMs.
- Overlays one solid-colour car sprite. The sprite position is updated through a valid/ready handshake and applied only at frame boundaries, so there is no tearing.
- Fixed 3-cycle pipeline.

Parameters:
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels.
- SPRITE_COLOR, 8'hE0, sprite colour (RRRGGGBB).
- SPRITE_X0, 304, sprite X after reset.
- SPRITE_Y0, 400, sprite Y after reset.

Ports:
- clock  in  1  pixel clock, the same clock that drives the timing generator
- reset  in  1  asynchronous, active-high reset
- pixel_x  in  10  current pixel column from the timing generator
- pixel_y  in  10  current pixel row from the timing generator
- video_on_in  in  1  visible-area flag
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- sprite_x_req  in  10  requested sprite left edge
- sprite_y_req  in  10  requested sprite top edge
- sprite_pos_valid  in  1  position request valid
- sprite_pos_ready  out  1  position buffer free
- map_addr  out  11  tile-map ROM address
- map_data  in  4  tile index; returned 1 cycle after map_addr
- tile_addr  out  12  pattern ROM address
- tile_data  in  8  pattern colour; returned 1 cycle after tile_addr
- rgb  out  8  pixel colour (RRRGGGBB)
- hsync_out  out  1  hsync delayed 3 cycles
- vsync_out  out  1  vsync delayed 3 cycles
- video_on_out  out  1  video_on delayed 3 cycles

Behaviour:
- Reset values:
  - rgb=0, video_on_out=0, hsync_out=1, vsync_out=1.
  - sprite_pos_ready=1, pending buffer empty.
  - Active sprite position = (SPRITE_X0, SPRITE_Y0).
  - All pipeline valid/sync bits return to the same reset values; reset applied mid-frame discards all in-flight pixels.
- Stage 0 (cycle n):
  - map_addr = (pixel_y>>4)*40 + (pixel_x>>4), combinational.
  - map_addr is forced to 0 when video_on_in=0 (coordinates are out of range during blanking).
  - Sprite hit is computed with 11-bit arithmetic: hit = x>=sx && x<sx+SPRITE_W && y>=sy && y<sy+SPRITE_H. There is no wrap; a sprite partially off-screen clips naturally.
  - Stage-1 registers capture x[3:0], y[3:0], hit, video_on, hsync, vsync.
- Stage 1 (cycle n+1):
  - tile_addr = {map_data, y1[3:0], x1[3:0]}, combinational.
  - Stage-2 registers shift hit and the sync/video bits.
- Stage 2 (cycle n+2): output registers load at the end of this cycle.
  - rgb = 0 if video_on is 0.
  - Otherwise rgb = SPRITE_COLOR if hit.
  - Otherwise rgb = tile_data.
- Output: rgb, hsync_out, vsync_out and video_on_out all valid at n+3. Latency is exactly 3 cycles for every signal, with no exceptions.
- Sprite handshake:
  - Transfer occurs when sprite_pos_valid && sprite_pos_ready; the pending buffer loads the request and sprite_pos_ready drops to 0 on the next cycle.
  - The request side must hold sprite_x_req/sprite_y_req stable while valid=1 and ready=0.
- Frame boundary:
  - Defined as the cycle with pixel_x==0 && pixel_y==480 (the first blanking line).
  - If the pending buffer is full at the boundary, the active position is loaded from it and the buffer empties; sprite_pos_ready is 1 on the next cycle.
  - If a transfer coincides with a boundary (buffer empty at that cycle), the boundary changes nothing and the new value waits for the next boundary.
  - Active position never changes during the visible area.

Optional Feature:
- Macro: RENDER_DEBUG_GRID_EN.
- Defined: during video_on, pixels with x[3:0]==0 or y[3:0]==0 output 8'hFF (white grid). Grid has priority over tile colour but not over the sprite. Latency is unchanged.
- Undefined: no grid logic is generated, and behaviour is exactly as described above.

Decomposition:
- Shared package vga_pkg holds:
  - H_VISIBLE=640, V_VISIBLE=480, TILE_SHIFT=4, MAP_COLS=40.
  - Typedef rgb8_t (8-bit colour).
  - Typedef pixel_coord_t (10-bit coordinate).
- One sub-module, sprite_pos_buffer, holds the pending/active position registers, the handshake and the frame-boundary load.
- The renderer instantiates sprite_pos_buffer and keeps the pipeline itself.

Test Plan:
- Reset released, timing generator running with a map ROM of all index 0 and a pattern ROM returning 8'h1C → rgb=8'h1C on visible pixels outside the sprite, 0 in blanking. hsync_out/vsync_out equal hsync_in/vsync_in delayed exactly 3 cycles.
- Default sprite position (304,400), pixel (304,400) presented at cycle n → rgb=8'hE0 at n+3. Pixel (336,400) → tile colour, since the right edge is exclusive.
- Map ROM with index=pixel tile column, input pixel (35,17) → map_addr=42, and at n+1 tile_addr={4'd2,4'd1,4'd3}=12'h213.
- Position (100,50) sent with valid mid-visible-frame → ready=0 next cycle, sprite remains at its old position until pixel_y==480, pixel_x==0. Then the new position takes effect and ready returns to 1.
- Sprite at x=620, y=470 → hit on columns 620-639 and rows 470-479 only, with no wrap hits at low x/y. Reset asserted mid-line → all outputs go to reset values immediately (asynchronous), and the position returns to (304,400).
- With RENDER_DEBUG_GRID_EN defined, pixel (32,5) outside the sprite → rgb=8'hFF. Pixel (33,5) → tile colour.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
// Screen geometry, tile-map shape and common typedefs.
package vga_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS   = 40;

  typedef logic [7:0] rgb8_t;
  typedef logic [9:0] pixel_coord_t;

endpackage

// File: rtl/sprite_pos_buffer.sv
// Pending/active sprite position with valid/ready intake.
// The active position only changes on the frame-boundary strobe.
module sprite_pos_buffer
  import vga_pkg::*;
#(
  parameter int X0 = 304,
  parameter int Y0 = 400
) (
  input  logic         clock,
  input  logic         reset,
  input  pixel_coord_t x_req_i,
  input  pixel_coord_t y_req_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         frame_boundary_i,
  output pixel_coord_t sx_o,
  output pixel_coord_t sy_o
);

  logic         full_q, full_d;
  pixel_coord_t px_q, px_d;
  pixel_coord_t py_q, py_d;
  pixel_coord_t ax_q, ax_d;
  pixel_coord_t ay_q, ay_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      ax_q   <= pixel_coord_t'(X0);
      ay_q   <= pixel_coord_t'(Y0);
    end else begin
      full_q <= full_d;
      px_q   <= px_d;
      py_q   <= py_d;
      ax_q   <= ax_d;
      ay_q   <= ay_d;
    end
  end

  // A request landing on a boundary with an empty buffer waits a frame.
  always_comb begin
    full_d = full_q;
    px_d   = px_q;
    py_d   = py_q;
    ax_d   = ax_q;
    ay_d   = ay_q;
    if (frame_boundary_i && full_q) begin
      ax_d   = px_q;
      ay_d   = py_q;
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      px_d   = x_req_i;
      py_d   = y_req_i;
      full_d = 1'b1;
    end
  end

  assign ready_o = !full_q;
  assign sx_o    = ax_q;
  assign sy_o    = ay_q;

endmodule

// File: rtl/vga_pixel_renderer.sv
// Tile background plus one solid sprite, fixed 3-cycle pipeline.
// Define RENDER_DEBUG_GRID_EN to overlay a white 16-pixel grid.
module vga_pixel_renderer
  import vga_pkg::*;
#(
  parameter int    SPRITE_W     = 32,
  parameter int    SPRITE_H     = 32,
  parameter rgb8_t SPRITE_COLOR = 8'hE0,
  parameter int    SPRITE_X0    = 304,
  parameter int    SPRITE_Y0    = 400
) (
  input  logic         clock,
  input  logic         reset,
  input  pixel_coord_t pixel_x,
  input  pixel_coord_t pixel_y,
  input  logic         video_on_in,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  pixel_coord_t sprite_x_req,
  input  pixel_coord_t sprite_y_req,
  input  logic         sprite_pos_valid,
  output logic         sprite_pos_ready,
  output logic [10:0]  map_addr,
  input  logic [3:0]   map_data,
  output logic [11:0]  tile_addr,
  input  rgb8_t        tile_data,
  output rgb8_t        rgb,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         video_on_out
);

  pixel_coord_t sx, sy;
  logic         boundary;

  assign boundary = (pixel_x == '0) &&
                    (pixel_y == pixel_coord_t'(V_VISIBLE));

  sprite_pos_buffer #(
    .X0 (SPRITE_X0),
    .Y0 (SPRITE_Y0)
  ) u_pos (
    .clock            (clock),
    .reset            (reset),
    .x_req_i          (sprite_x_req),
    .y_req_i          (sprite_y_req),
    .valid_i          (sprite_pos_valid),
    .ready_o          (sprite_pos_ready),
    .frame_boundary_i (boundary),
    .sx_o             (sx),
    .sy_o             (sy)
  );

  // Stage 0: map lookup and sprite hit, widened to avoid wrap.
  logic [10:0] trow, tcol;
  logic [10:0] x11, y11, sx11, sy11;
  logic        hit_d;

  assign trow = 11'(pixel_y >> TILE_SHIFT);
  assign tcol = 11'(pixel_x >> TILE_SHIFT);
  assign map_addr = video_on_in ?
                    trow * 11'(MAP_COLS) + tcol : '0;

  assign x11  = {1'b0, pixel_x};
  assign y11  = {1'b0, pixel_y};
  assign sx11 = {1'b0, sx};
  assign sy11 = {1'b0, sy};
  assign hit_d = (x11 >= sx11) &&
                 (x11 < sx11 + 11'(SPRITE_W)) &&
                 (y11 >= sy11) &&
                 (y11 < sy11 + 11'(SPRITE_H));

  logic [3:0] x1_q, y1_q;
  logic       hit1_q, von1_q, hs1_q, vs1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x1_q   <= '0;
      y1_q   <= '0;
      hit1_q <= 1'b0;
      von1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      x1_q   <= pixel_x[3:0];
      y1_q   <= pixel_y[3:0];
      hit1_q <= hit_d;
      von1_q <= video_on_in;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
    end
  end

  // Stage 1: pattern lookup.
  assign tile_addr = {map_data, y1_q, x1_q};

  logic hit2_q, von2_q, hs2_q, vs2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit2_q <= 1'b0;
      von2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      hit2_q <= hit1_q;
      von2_q <= von1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

`ifdef RENDER_DEBUG_GRID_EN
  logic grid2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grid2_q <= 1'b0;
    end else begin
      grid2_q <= (x1_q == 4'd0) || (y1_q == 4'd0);
    end
  end
`endif

  // Stage 2: colour select, later assignments take priority.
  rgb8_t rgb_d;

  always_comb begin
    rgb_d = tile_data;
`ifdef RENDER_DEBUG_GRID_EN
    if (grid2_q) rgb_d = 8'hFF;
`endif
    if (hit2_q) rgb_d = SPRITE_COLOR;
    if (!von2_q) rgb_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb          <= '0;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
    end else begin
      rgb          <= rgb_d;
      video_on_out <= von2_q;
      hsync_out    <= hs2_q;
      vsync_out    <= vs2_q;
    end
  end

endmodule
